// File: rtl/nn_phase_sequencer_pkg.sv
// Shared types and helpers for the phase sequencer: control-state enum and a
// ceiling-log2 used to size the phase index.
package nn_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nn_phase_sequencer_if.sv
// Control/status bundle of the phase sequencer; the sequencer sits on the
// slave modport, its controller on the master modport.
interface nn_phase_sequencer_if #(
  parameter int NUM_PHASES = 16,
  parameter int WRAP_W     = 8
);
  import nn_phase_sequencer_pkg::*;

  localparam int PH_W = clog2(NUM_PHASES);

  // No valid/ready flow control: start/advance/abort are levels sampled on
  // every rising clk edge, and all status outputs are registered.
  logic              start;
  logic              advance;
  logic              abort;
  logic              one_shot;
  logic [PH_W-1:0]   last_phase;
  logic [PH_W-1:0]   phase;
  logic              busy;
  logic              done;
  logic [WRAP_W-1:0] wrap_cnt;
  state_t            state;

  modport master (
    output start, advance, abort, one_shot, last_phase,
    input  phase, busy, done, wrap_cnt, state
  );

  modport slave (
    input  start, advance, abort, one_shot, last_phase,
    output phase, busy, done, wrap_cnt, state
  );

endinterface

// File: rtl/nn_phase_sequencer_counter.sv
// Phase register with latched (clamped) terminal; flags the advance that
// completes a pass so the control FSM can wrap or finish.
module nn_phase_counter #(
  parameter int NUM_PHASES = 16,
  parameter int PH_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clr,
  input  logic            step,
  input  logic            stay,
  input  logic [PH_W-1:0] last_phase,
  output logic [PH_W-1:0] phase,
  output logic            wrap
);

  localparam logic [PH_W-1:0] MAX_IDX = PH_W'(NUM_PHASES - 1);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] term_q;
  logic            at_term;

  assign at_term = (phase_q == term_q);
  assign wrap    = step && at_term;
  assign phase   = phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      term_q  <= MAX_IDX;
    end else if (load) begin
      phase_q <= '0;
      term_q  <= (last_phase > MAX_IDX) ? MAX_IDX : last_phase;
    end else if (clr) begin
      phase_q <= '0;
    end else if (step) begin
      // A one-shot pass parks on the terminal for its DONE cycle.
      if (!at_term)  phase_q <= phase_q + 1'b1;
      else if (!stay) phase_q <= '0;
    end
  end

endmodule

// File: rtl/nn_phase_sequencer.sv
// Phase sequencer top: IDLE/RUN/DONE control FSM, wrap counter and the
// phase counter sub-block.
module nn_phase_sequencer
  import nn_phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = 16,
  parameter int WRAP_W     = 8
) (
  input logic                clk,
  input logic                rst_n,
  nn_phase_sequencer_if.slave bus
);

  localparam int PH_W = clog2(NUM_PHASES);

  state_t            state;
  state_t            state_nx;
  logic              one_shot_q;
  logic              busy_q;
  logic              done_q;
  logic [WRAP_W-1:0] wrap_q;
  logic [PH_W-1:0]   phase_w;
  logic              load;
  logic              step;
  logic              clr;
  logic              wrap;

  assign load = (state == ST_IDLE) && bus.start && !bus.abort;
  assign step = (state == ST_RUN) && bus.advance && !bus.abort;
  assign clr  = ((state != ST_IDLE) && bus.abort) || (state == ST_DONE);

  nn_phase_counter #(
    .NUM_PHASES (NUM_PHASES),
    .PH_W       (PH_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .clr        (clr),
    .step       (step),
    .stay       (one_shot_q),
    .last_phase (bus.last_phase),
    .phase      (phase_w),
    .wrap       (wrap)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (load) state_nx = ST_RUN;
      ST_RUN: begin
        if (bus.abort)             state_nx = ST_IDLE;
        else if (wrap && one_shot_q) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      one_shot_q <= 1'b0;
      wrap_q     <= '0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx == ST_RUN);
      done_q <= (state_nx == ST_DONE);
      if (load) begin
        one_shot_q <= bus.one_shot;
        wrap_q     <= '0;
      end else if (wrap && !one_shot_q) begin
        wrap_q <= wrap_q + 1'b1;
      end
    end
  end

  assign bus.phase    = phase_w;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wrap_cnt = wrap_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_nn_phase_sequencer.sv
// Bench for nn_phase_sequencer: two instances (16 phases/8-bit wraps and
// 12 phases/2-bit wraps) driven in lockstep and compared to a reference model.
module tb_nn_phase_sequencer;

  logic clk;
  logic rst_n;
  logic t_start, t_advance, t_abort, t_one_shot;
  logic [3:0] t_last_phase;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one slot per instance (0: a, 1: b).
  int np[2] = '{16, 12};
  int wm[2] = '{256, 4};
  int m_mode[2];   // 0 idle, 1 running, 2 done cycle
  int m_phase[2];
  int m_wraps[2];
  int m_term[2];
  int m_os[2];

  nn_phase_sequencer_if #(.NUM_PHASES(16), .WRAP_W(8)) if_a ();
  nn_phase_sequencer_if #(.NUM_PHASES(12), .WRAP_W(2)) if_b ();

  assign if_a.start      = t_start;
  assign if_a.advance    = t_advance;
  assign if_a.abort      = t_abort;
  assign if_a.one_shot   = t_one_shot;
  assign if_a.last_phase = t_last_phase;
  assign if_b.start      = t_start;
  assign if_b.advance    = t_advance;
  assign if_b.abort      = t_abort;
  assign if_b.one_shot   = t_one_shot;
  assign if_b.last_phase = t_last_phase;

  nn_phase_sequencer #(.NUM_PHASES(16), .WRAP_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  nn_phase_sequencer #(.NUM_PHASES(12), .WRAP_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i]  = 0;
      m_phase[i] = 0;
      m_wraps[i] = 0;
      m_term[i]  = np[i] - 1;
      m_os[i]    = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      case (m_mode[i])
        0: begin
          m_phase[i] = 0;
          if (t_start && !t_abort) begin
            m_mode[i]  = 1;
            m_wraps[i] = 0;
            m_term[i]  = (int'(t_last_phase) > np[i] - 1) ? np[i] - 1 : int'(t_last_phase);
            m_os[i]    = int'(t_one_shot);
          end
        end
        1: begin
          if (t_abort) begin
            m_mode[i]  = 0;
            m_phase[i] = 0;
          end else if (t_advance) begin
            if (m_phase[i] < m_term[i]) m_phase[i]++;
            else if (m_os[i] != 0)      m_mode[i] = 2;
            else begin
              m_phase[i] = 0;
              m_wraps[i]++;
            end
          end
        end
        default: begin
          m_mode[i]  = 0;
          m_phase[i] = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".a_phase"}, 32'(if_a.phase),    m_phase[0]);
    check_eq({tag, ".a_busy"},  32'(if_a.busy),     (m_mode[0] == 1) ? 1 : 0);
    check_eq({tag, ".a_done"},  32'(if_a.done),     (m_mode[0] == 2) ? 1 : 0);
    check_eq({tag, ".a_wrap"},  32'(if_a.wrap_cnt), m_wraps[0] % wm[0]);
    check_eq({tag, ".b_phase"}, 32'(if_b.phase),    m_phase[1]);
    check_eq({tag, ".b_busy"},  32'(if_b.busy),     (m_mode[1] == 1) ? 1 : 0);
    check_eq({tag, ".b_done"},  32'(if_b.done),     (m_mode[1] == 2) ? 1 : 0);
    check_eq({tag, ".b_wrap"},  32'(if_b.wrap_cnt), m_wraps[1] % wm[1]);
  endtask

  // Driver tasks: inputs change at posedge+1, outputs are sampled there too.
  task automatic set_in(input logic s, input logic adv, input logic ab,
                        input logic os, input logic [3:0] lp);
    t_start      = s;
    t_advance    = adv;
    t_abort      = ab;
    t_one_shot   = os;
    t_last_phase = lp;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(posedge clk);
    #1;
    compare_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  task automatic abort_to_idle(input string tag);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    cycle(tag);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cycle(tag);
  endtask

  initial begin
    int exp_b_wrap[5];
    logic toggles[4];
    exp_b_wrap = '{1, 2, 3, 0, 1};
    toggles    = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all("reset");
    rst_n = 1'b1;

    // Continuous wrap, full range.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd15);
    cycle("wrap16.start");
    t_start = 1'b0;
    repeat (16) cycle("wrap16");
    check_eq("wrap16.end_phase", 32'(if_a.phase), 0);
    check_eq("wrap16.end_wrap",  32'(if_a.wrap_cnt), 1);
    check_eq("wrap16.end_busy",  32'(if_a.busy), 1);
    abort_to_idle("wrap16.abort");

    // One-shot to phase 3.
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
    cycle("os3.start");
    t_start = 1'b0;
    repeat (4) cycle("os3");
    check_eq("os3.done", 32'(if_a.done), 1);
    check_eq("os3.hold_phase", 32'(if_a.phase), 3);
    repeat (2) cycle("os3.tail");

    // Clamp: instance b has 12 phases so terminal 14 clamps to 11.
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd14);
    cycle("clamp.start");
    t_start = 1'b0;
    repeat (12) cycle("clamp");
    check_eq("clamp.b_done", 32'(if_b.done), 1);
    check_eq("clamp.b_phase", 32'(if_b.phase), 11);
    repeat (6) cycle("clamp.tail");

    // Advance toggling, start pulsed mid-run.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
    cycle("toggle.start");
    for (int k = 0; k < 4; k++) begin
      set_in((k == 1), toggles[k], 1'b0, 1'b0, 4'd15);
      cycle("toggle");
    end
    check_eq("toggle.phase", 32'(if_a.phase), 2);
    abort_to_idle("toggle.abort");

    // Abort beats advance at phase 7.
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
    cycle("abort.start");
    t_start = 1'b0;
    repeat (7) cycle("abort.run");
    check_eq("abort.at7", 32'(if_a.phase), 7);
    t_abort = 1'b1;
    cycle("abort.hit");
    check_eq("abort.phase", 32'(if_a.phase), 0);
    check_eq("abort.no_done", 32'(if_a.done), 0);
    t_abort = 1'b0;

    // Asynchronous reset at phase 5.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd15);
    cycle("rst.start");
    t_start = 1'b0;
    repeat (5) cycle("rst.run");
    check_eq("rst.at5", 32'(if_a.phase), 5);
    do_async_reset("rst");
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
    repeat (2) cycle("rst.idle_wait");

    // Terminal 0 with 2-bit wrap counter.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cycle("term0.start");
    t_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle("term0");
      check_eq("term0.b_wrap_seq", 32'(if_b.wrap_cnt), exp_b_wrap[k]);
    end

    // Abort in IDLE blocks start.
    abort_to_idle("blk.pre");
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
    cycle("blk");
    check_eq("blk.busy", 32'(if_a.busy), 0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cycle("blk.after");

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) == 0) do_async_reset("rnd");
      else cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
